// File: rtl/kmac_state_snapshot.sv
// Holds the Keccak state shares between the sha3 core and the state-read window.
// Captures on squeeze pulses and scrubs the held copy lane by lane on clear.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// ST_IDLE   | nothing held, state_o is zero
// ST_HELD   | a captured state is presented on state_o
// ST_WLANE  | overwriting lanes with entropy, one lane per entropy beat
// ST_WZERO  | single cycle: zero all shares, pulse wipe_done_o
module kmac_state_snapshot #(
  parameter bit EnMasking     = 1'b0,
  parameter bit EnEntropyWipe = 1'b0,
  parameter int LaneW         = 64,
  localparam int Share        = EnMasking ? 2 : 1,
  localparam int StateW       = 25 * LaneW
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      state_valid_i,
  input  logic [Share*StateW-1:0]   state_i,
  input  logic                      clear_i,
  input  logic [LaneW-1:0]          entropy_i,
  input  logic                      entropy_valid_i,
  output logic                      entropy_ack_o,
  output logic [Share*StateW-1:0]   state_o,
  output logic                      state_valid_o,
  output logic                      busy_o,
  output logic                      wipe_done_o,
  output logic                      capture_err_o
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_HELD  = 2'd1;
  localparam logic [1:0] ST_WLANE = 2'd2;
  localparam logic [1:0] ST_WZERO = 2'd3;

  logic [1:0]                fsm_q, fsm_d;
  logic [4:0]                lane_cnt_q, lane_cnt_d;
  logic [Share*StateW-1:0]   st_q, st_d;
  logic                      err_q, err_d;

  always_comb begin
    fsm_d      = fsm_q;
    lane_cnt_d = lane_cnt_q;
    st_d       = st_q;
    err_d      = err_q;
    case (fsm_q)
      ST_IDLE: begin
        if (clear_i) begin
          fsm_d = ST_WZERO;
        end else if (state_valid_i) begin
          st_d  = state_i;
          fsm_d = ST_HELD;
        end
      end
      ST_HELD: begin
        // clear takes priority over a same-cycle squeeze
        if (clear_i) begin
          fsm_d      = EnEntropyWipe ? ST_WLANE : ST_WZERO;
          lane_cnt_d = 5'd0;
        end else if (state_valid_i) begin
          st_d = state_i;
        end
      end
      ST_WLANE: begin
        if (state_valid_i) err_d = 1'b1;
        if (entropy_valid_i) begin
          for (int s = 0; s < Share; s++) begin
            for (int k = 0; k < 25; k++) begin
              if (lane_cnt_q == 5'(k)) st_d[s*StateW + k*LaneW +: LaneW] = entropy_i;
            end
          end
          if (lane_cnt_q == 5'd24) begin
            fsm_d      = ST_WZERO;
            lane_cnt_d = 5'd0;
          end else begin
            lane_cnt_d = lane_cnt_q + 5'd1;
          end
        end
      end
      ST_WZERO: begin
        if (state_valid_i) err_d = 1'b1;
        st_d  = '0;
        fsm_d = ST_IDLE;
      end
      default: fsm_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      fsm_q      <= ST_IDLE;
      lane_cnt_q <= 5'd0;
      st_q       <= '0;
      err_q      <= 1'b0;
    end else begin
      fsm_q      <= fsm_d;
      lane_cnt_q <= lane_cnt_d;
      st_q       <= st_d;
      err_q      <= err_d;
    end
  end

  assign state_o       = st_q;
  assign state_valid_o = (fsm_q == ST_HELD);
  assign busy_o        = (fsm_q == ST_WLANE) || (fsm_q == ST_WZERO);
  assign wipe_done_o   = (fsm_q == ST_WZERO);
  assign entropy_ack_o = (fsm_q == ST_WLANE) && entropy_valid_i;
  assign capture_err_o = err_q;

endmodule

// File: tb/tb_kmac_state_snapshot.sv
// Scoreboard bench: two snapshot instances (masked+entropy wipe, unmasked+plain wipe)
// share one stimulus stream and are checked against a lane-array reference model.
module tb_kmac_state_snapshot;
  localparam int LW = 16;
  localparam int SW = 25 * LW;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_n = 1'b0;
  logic            sv = 1'b0, clr = 1'b0, ev = 1'b0;
  logic [LW-1:0]   ent = '0;
  logic [2*SW-1:0] st_in = '0;

  logic [2*SW-1:0] m_state;
  logic            m_vld, m_busy, m_done, m_ack, m_err;
  logic [SW-1:0]   p_state;
  logic            p_vld, p_busy, p_done, p_ack, p_err;

  kmac_state_snapshot #(.EnMasking(1'b1), .EnEntropyWipe(1'b1), .LaneW(LW)) u_dut_m (
    .clk_i(clk), .rst_ni(rst_n), .state_valid_i(sv), .state_i(st_in), .clear_i(clr),
    .entropy_i(ent), .entropy_valid_i(ev), .entropy_ack_o(m_ack), .state_o(m_state),
    .state_valid_o(m_vld), .busy_o(m_busy), .wipe_done_o(m_done), .capture_err_o(m_err));

  kmac_state_snapshot #(.EnMasking(1'b0), .EnEntropyWipe(1'b0), .LaneW(LW)) u_dut_p (
    .clk_i(clk), .rst_ni(rst_n), .state_valid_i(sv), .state_i(st_in[SW-1:0]), .clear_i(clr),
    .entropy_i(ent), .entropy_valid_i(ev), .entropy_ack_o(p_ack), .state_o(p_state),
    .state_valid_o(p_vld), .busy_o(p_busy), .wipe_done_o(p_done), .capture_err_o(p_err));

  typedef struct {
    logic [2*SW-1:0] st_m;
    logic [SW-1:0]   st_p;
    logic [4:0]      fl_m;
    logic [4:0]      fl_p;
  } exp_t;

  exp_t q[$];
  int n_tests = 0;
  int n_fail  = 0;

  // reference model: d=0 masked/entropy-wipe, d=1 plain; mode 0 empty,1 holding,2 scrubbing,3 zeroing
  logic [LW-1:0] lanes [2][2][25];
  int            mode [2];
  int            nxt [2];
  bit            err [2];

  bit              last_r = 1'b0, last_v = 1'b0, last_c = 1'b0, last_e = 1'b0;
  logic [LW-1:0]   last_en = '0;
  logic [2*SW-1:0] last_s = '0;

  function automatic int shares(input int d);
    return (d == 0) ? 2 : 1;
  endfunction

  task automatic zero_lanes(input int d);
    for (int s = 0; s < 2; s++) for (int k = 0; k < 25; k++) lanes[d][s][k] = '0;
  endtask

  task automatic load_lanes(input int d, input logic [2*SW-1:0] s_in);
    for (int s = 0; s < shares(d); s++)
      for (int k = 0; k < 25; k++) lanes[d][s][k] = s_in[s*SW + k*LW +: LW];
  endtask

  task automatic step(input int d, input bit r, input bit v, input bit c, input bit e,
                      input logic [LW-1:0] en, input logic [2*SW-1:0] s_in);
    if (!r) begin
      zero_lanes(d); mode[d] = 0; nxt[d] = 0; err[d] = 1'b0;
      return;
    end
    case (mode[d])
      0: if (c) mode[d] = 3; else if (v) begin load_lanes(d, s_in); mode[d] = 1; end
      1: if (c) begin mode[d] = (d == 0) ? 2 : 3; nxt[d] = 0; end
         else if (v) load_lanes(d, s_in);
      2: begin
        if (v) err[d] = 1'b1;
        if (e) begin
          for (int s = 0; s < shares(d); s++) lanes[d][s][nxt[d]] = en;
          nxt[d]++;
          if (nxt[d] == 25) begin mode[d] = 3; nxt[d] = 0; end
        end
      end
      default: begin
        if (v) err[d] = 1'b1;
        zero_lanes(d); mode[d] = 0;
      end
    endcase
  endtask

  function automatic logic [2*SW-1:0] pack(input int d);
    logic [2*SW-1:0] r = '0;
    for (int s = 0; s < shares(d); s++)
      for (int k = 0; k < 25; k++) r[s*SW + k*LW +: LW] = lanes[d][s][k];
    return r;
  endfunction

  function automatic logic [4:0] flags(input int d, input bit e);
    return {mode[d] == 1, mode[d] >= 2, mode[d] == 3, (mode[d] == 2) && e, err[d]};
  endfunction

  function automatic logic [2*SW-1:0] rnd_state();
    logic [2*SW-1:0] r;
    for (int i = 0; i < 2*SW; i += 32) r[i +: 32] = $urandom();
    return r;
  endfunction

  task automatic cyc(input bit r, input bit v, input bit c, input bit e,
                     input logic [LW-1:0] en, input logic [2*SW-1:0] s_in);
    exp_t x;
    @(posedge clk);
    for (int d = 0; d < 2; d++) step(d, last_r, last_v, last_c, last_e, last_en, last_s);
    #1;
    rst_n = r; sv = v; clr = c; ev = e; ent = en; st_in = s_in;
    last_r = r; last_v = v; last_c = c; last_e = e; last_en = en; last_s = s_in;
    x.st_m = pack(0);
    x.st_p = pack(1)[SW-1:0];
    x.fl_m = flags(0, e);
    x.fl_p = flags(1, 1'b0);
    q.push_back(x);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
  endtask

  function automatic void chk(input string name, input logic [2*SW-1:0] act, input logic [2*SW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  // flag order: {state_valid, busy, wipe_done, entropy_ack, capture_err}
  always @(negedge clk) begin
    exp_t x;
    if (q.size() > 0) begin
      x = q.pop_front();
      chk("state_masked", m_state, x.st_m);
      chk("state_plain", {{SW{1'b0}}, p_state}, {{SW{1'b0}}, x.st_p});
      chk("flags_masked", {{(2*SW-5){1'b0}}, m_vld, m_busy, m_done, m_ack, m_err},
          {{(2*SW-5){1'b0}}, x.fl_m});
      chk("flags_plain", {{(2*SW-5){1'b0}}, p_vld, p_busy, p_done, p_ack, p_err},
          {{(2*SW-5){1'b0}}, x.fl_p});
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2*SW-1:0] p;
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
    idle(2);
    // capture then re-squeeze
    p = rnd_state();
    cyc(1'b1, 1'b1, 1'b0, 1'b0, '0, p);
    idle(2);
    p = rnd_state();
    cyc(1'b1, 1'b1, 1'b0, 1'b0, '0, p);
    idle(2);
    // clear in Held: entropy wipe with entropy_valid toggling, plain wipe in one cycle
    cyc(1'b1, 1'b0, 1'b1, 1'b0, '0, '0);
    for (int i = 0; i < 50; i++) cyc(1'b1, 1'b0, 1'b0, (i % 2) == 0, LW'($urandom()), '0);
    idle(3);
    // clear while idle
    cyc(1'b1, 1'b0, 1'b1, 1'b0, '0, '0);
    for (int i = 0; i < 26; i++) cyc(1'b1, 1'b0, 1'b0, 1'b1, LW'($urandom()), '0);
    idle(2);
    // collision, then a squeeze during wipe
    cyc(1'b1, 1'b1, 1'b0, 1'b0, '0, rnd_state());
    idle(1);
    cyc(1'b1, 1'b1, 1'b1, 1'b0, '0, rnd_state());
    cyc(1'b1, 1'b1, 1'b0, 1'b0, '0, rnd_state());
    for (int i = 0; i < 26; i++) cyc(1'b1, 1'b0, 1'b0, 1'b1, LW'($urandom()), '0);
    idle(3);
    // reset mid-wipe at lane 10
    cyc(1'b1, 1'b1, 1'b0, 1'b0, '0, rnd_state());
    cyc(1'b1, 1'b0, 1'b1, 1'b0, '0, '0);
    for (int i = 0; i < 10; i++) cyc(1'b1, 1'b0, 1'b0, 1'b1, LW'($urandom()), '0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, LW'($urandom()), '0);
    idle(3);
    // constrained-random traffic
    for (int i = 0; i < 400; i++)
      cyc($urandom_range(99) != 0, $urandom_range(9) == 0, $urandom_range(19) == 0,
          $urandom_range(1) == 1, LW'($urandom()), rnd_state());
    idle(3);
    @(posedge clk);
    @(negedge clk);
    #1;
    n_tests++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
